// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic [4:0] TRIG_L0 = 5'd1;
  localparam logic [4:0] TRIG_L1 = 5'd4;
  localparam logic [4:0] TRIG_L2 = 5'd8;
  localparam logic [4:0] TRIG_L3 = 5'd14;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // start + data + optional parity + one stop bit
  function automatic logic [3:0] frame_bits(input logic [1:0] wls, input logic pen);
    return 4'd7 + {2'b00, wls} + {3'b000, pen};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: selectable 1-entry / DEPTH-entry capacity, flush, and a count of flagged entries.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fifo_mode,
  input  logic                     push,
  input  rx_entry_t                wdata,
  input  logic                     pop,
  output rx_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     err_any,
  output logic                     overrun,
  output logic                     pop_ok
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cap, err_cnt;
  logic          full, wr_ok, wr_err, pop_err;

  assign cap     = fifo_mode ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign empty   = (count == '0);
  // >= keeps a FIFO that was filled in FIFO mode "full" after switching to 1-entry mode
  assign full    = (count >= cap);
  assign pop_ok  = pop && !empty;
  assign wr_ok   = push && (!full || pop_ok);
  assign overrun = push && full && !pop_ok;
  assign head    = mem[rd_ptr];
  assign wr_err  = wr_ok && (wdata.bi || wdata.fe || wdata.pe);
  assign pop_err = pop_ok && (head.bi || head.fe || head.pe);
  assign err_any = (err_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({wr_err, pop_err})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: RXD synchronizer, 16x-oversampled frame FSM, receive FIFO,
// overrun, trigger-level and character-timeout status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       apb_clk_in,
  input  logic       apb_rst_in,
  input  logic       bclk_en_in,
  input  logic       uart_rxd_in,
  input  logic       urrst_in,
  input  logic [1:0] wls_in,
  input  logic       pen_in,
  input  logic       eps_in,
  input  logic       sp_in,
  input  logic       fifoen_in,
  input  logic [1:0] rxfiftl_in,
  input  logic       rxclr_in,
  input  logic       rbr_rd_in,
  input  logic       lsr_rd_in,
  output logic [7:0] rbr_out,
  output logic       dr_out,
  output logic       pe_out,
  output logic       fe_out,
  output logic       bi_out,
  output logic       oe_out,
  output logic       rxfifoe_out,
  output logic       rx_trig_out,
  output logic       rx_timeout_out
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic rst;
  assign rst = apb_rst_in || !urrst_in;

  logic sync1, sync2, rxd;
  always_ff @(posedge apb_clk_in) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rxd_in;
      sync2 <= sync1;
    end
  end
  assign rxd = sync2;

  rx_state_t     state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bidx, last_idx;
  logic [7:0]    shreg;
  logic          par_bit, par_err, exp_par, is_break, push;
  rx_entry_t     push_entry;

  assign last_idx   = 3'd4 + {1'b0, wls_in};
  assign exp_par    = sp_in ? ~eps_in : (eps_in ? ^shreg : ~^shreg);
  assign is_break   = (shreg == 8'h00) && (!pen_in || !par_bit) && !rxd;
  assign push       = bclk_en_in && (state == ST_STOP) && (tcnt == LAST);
  assign push_entry = '{bi: is_break, fe: !rxd, pe: par_err, data: is_break ? 8'h00 : shreg};

  always_ff @(posedge apb_clk_in) begin
    if (rst) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      bidx    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else if (bclk_en_in) begin
      tcnt <= (tcnt == LAST) ? '0 : tcnt + 1'b1;
      unique case (state)
        ST_IDLE:
          if (!rxd) begin
            state <= ST_START;
            tcnt  <= '0;
          end
        ST_START:
          if (tcnt == MID) begin
            tcnt <= '0;
            if (rxd) state <= ST_IDLE;
            else begin
              state   <= ST_DATA;
              bidx    <= '0;
              shreg   <= '0;
              par_bit <= 1'b0;
              par_err <= 1'b0;
            end
          end
        ST_DATA:
          if (tcnt == LAST) begin
            shreg[bidx] <= rxd;
            // >= so a word length shrunk mid-frame still terminates
            if (bidx >= last_idx) state <= pen_in ? ST_PARITY : ST_STOP;
            else bidx <= bidx + 1'b1;
          end
        ST_PARITY:
          if (tcnt == LAST) begin
            par_bit <= rxd;
            par_err <= (rxd != exp_par);
            state   <= ST_STOP;
          end
        ST_STOP:
          if (tcnt == LAST) state <= is_break ? ST_BREAK : ST_IDLE;
        ST_BREAK:
          if (rxd) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_entry_t     head;
  logic [CW-1:0] count;
  logic          empty, err_any, overrun, pop_ok;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (apb_clk_in),
    .rst       (rst),
    .flush     (rxclr_in),
    .fifo_mode (fifoen_in),
    .push      (push),
    .wdata     (push_entry),
    .pop       (rbr_rd_in),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .err_any   (err_any),
    .overrun   (overrun),
    .pop_ok    (pop_ok)
  );

  logic oe;
  always_ff @(posedge apb_clk_in) begin
    if (rst)                         oe <= 1'b0;
    else if (overrun)                oe <= 1'b1;
    else if (lsr_rd_in || rxclr_in)  oe <= 1'b0;
  end

  logic [4:0] trig_level;
  always_comb begin
    trig_level = TRIG_L0;
    case (rxfiftl_in)
      2'd1:    trig_level = TRIG_L1;
      2'd2:    trig_level = TRIG_L2;
      2'd3:    trig_level = TRIG_L3;
      default: trig_level = TRIG_L0;
    endcase
  end

  // counter saturates at the limit, so the timeout holds until one of the clears
  logic [11:0] to_cnt, to_limit;
  assign to_limit = 12'(TIMEOUT_CHARS * OVERSAMPLE) * {8'h00, frame_bits(wls_in, pen_in)};

  always_ff @(posedge apb_clk_in) begin
    if (rst || !fifoen_in || empty || push || pop_ok || rxclr_in) to_cnt <= '0;
    else if (bclk_en_in && to_cnt < to_limit)                     to_cnt <= to_cnt + 1'b1;
  end

  assign rbr_out        = empty ? 8'h00 : head.data;
  assign dr_out         = !empty;
  assign pe_out         = !empty && head.pe;
  assign fe_out         = !empty && head.fe;
  assign bi_out         = !empty && head.bi;
  assign oe_out         = oe;
  assign rxfifoe_out    = fifoen_in && err_any;
  assign rx_trig_out    = fifoen_in ? (32'(count) >= 32'(trig_level)) : !empty;
  assign rx_timeout_out = fifoen_in && !empty && (to_cnt >= to_limit);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are driven bit-by-bit, the expected
// FIFO entry is queued from a rule-level model, and a monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bclk_en, rxd, urrst, pen, eps, sp, fifoen, rxclr, lsr_rd;
  logic       mon_rd, man_rd, rbr_rd;
  logic [1:0] wls, rxfiftl;
  logic [7:0] rbr;
  logic       dr, pe_o, fe_o, bi_o, oe, rxfifoe, rx_trig, rx_timeout;

  assign rbr_rd = mon_rd | man_rd;

  uart_rx dut (
    .apb_clk_in     (clk),
    .apb_rst_in     (rst),
    .bclk_en_in     (bclk_en),
    .uart_rxd_in    (rxd),
    .urrst_in       (urrst),
    .wls_in         (wls),
    .pen_in         (pen),
    .eps_in         (eps),
    .sp_in          (sp),
    .fifoen_in      (fifoen),
    .rxfiftl_in     (rxfiftl),
    .rxclr_in       (rxclr),
    .rbr_rd_in      (rbr_rd),
    .lsr_rd_in      (lsr_rd),
    .rbr_out        (rbr),
    .dr_out         (dr),
    .pe_out         (pe_o),
    .fe_out         (fe_o),
    .bi_out         (bi_o),
    .oe_out         (oe),
    .rxfifoe_out    (rxfifoe),
    .rx_trig_out    (rx_trig),
    .rx_timeout_out (rx_timeout)
  );

  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          started = 1'b0;
  bit          auto_read = 1'b0;
  logic [10:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // 16x tick on every 4th clock
  initial begin
    bclk_en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bclk_en = 1'b1;
      @(posedge clk);
      #1 bclk_en = 1'b0;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {bi,fe,pe,data} from the character's bits and the line-control settings
  function automatic logic [10:0] model(input logic [7:0] d, input logic par, input logic stop,
                                        input logic [1:0] w, input logic pe_en, input logic e,
                                        input logic s);
    logic [7:0] dm;
    int         ones;
    logic       want, p_err, brk, f_err;
    dm   = d & 8'((9'd1 << (5 + w)) - 9'd1);
    ones = $countones(dm);
    if (s)      want = ~e;
    else if (e) want = (ones % 2 == 1);
    else        want = (ones % 2 == 0);
    p_err = pe_en && (par != want);
    brk   = (dm == 8'h00) && (!pe_en || !par) && !stop;
    f_err = !stop || brk;
    return {brk, f_err, p_err, brk ? 8'h00 : dm};
  endfunction

  task automatic hold_bit();
    repeat (64) @(posedge clk);
    #2;
  endtask

  task automatic align_tick();
    do @(posedge clk); while (bclk_en !== 1'b1);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit store);
    int n;
    n = 5 + wls;
    if (store) exp_q.push_back(model(d, par, stop, wls, pen, eps, sp));
    align_tick();
    start_cyc = cyc;
    started   = 1'b1;
    rxd = 1'b0; hold_bit();
    for (int i = 0; i < n; i++) begin rxd = d[i]; hold_bit(); end
    if (pen) begin rxd = par; hold_bit(); end
    rxd = stop; hold_bit();
    rxd = 1'b1; hold_bit();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d entries outstanding, expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: whenever enabled and data is ready, compare head with the scoreboard and pop it
  initial begin
    logic [10:0] e;
    mon_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_read && dr) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_entry: got %0h expected none", {bi_o, fe_o, pe_o, rbr});
        end else begin
          tests--;
          e = exp_q.pop_front();
          check("rx_entry", {21'h0, bi_o, fe_o, pe_o, rbr}, {21'h0, e});
        end
        mon_rd = 1'b1;
        @(posedge clk);
        #1 mon_rd = 1'b0;
      end
    end
  end

  initial begin
    int          offset, push_cyc, n, lim, k;
    logic [10:0] e;
    rst = 1'b1; urrst = 1'b1; rxd = 1'b1; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    fifoen = 1'b1; rxfiftl = 2'd0; rxclr = 1'b0; lsr_rd = 1'b0; man_rd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_flags", {dr, pe_o, fe_o, bi_o, oe, rxfifoe, rx_trig, rx_timeout}, 0);
    check("reset_rbr", rbr, 0);

    // 8N1 basic character
    auto_read = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    drain("t1");
    check("t1_dr_after_read", dr, 0);

    // 7E1 with a wrong parity bit
    auto_read = 1'b0; wls = 2'd2; pen = 1'b1; eps = 1'b1;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    e = exp_q[0];
    check("t2_rxfifoe_set", rxfifoe, |e[10:8]);
    check("t2_dr", dr, 1);
    auto_read = 1'b1;
    drain("t2");
    check("t2_rxfifoe_clear", rxfifoe, 0);

    // false start then a valid character
    wls = 2'd3; pen = 1'b0; eps = 1'b0;
    align_tick();
    rxd = 1'b0;
    repeat (16) @(posedge clk);
    #2 rxd = 1'b1;
    repeat (20 * 64) @(posedge clk);
    @(negedge clk);
    check("t3_false_start_dr", dr, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    drain("t3");

    // overrun in 1-entry mode
    auto_read = 1'b0; fifoen = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_oe_set", oe, 1);
    lsr_rd = 1'b1;
    @(posedge clk);
    #1 lsr_rd = 1'b0;
    @(negedge clk);
    check("t4_oe_cleared", oe, 0);
    auto_read = 1'b1;
    drain("t4a");

    // full FIFO with pop coinciding with push: calibrate push time from frame start
    auto_read = 1'b0; fifoen = 1'b1; rxfiftl = 2'd3; started = 1'b0; push_cyc = 0;
    fork
      send_frame(8'h80, 1'b0, 1'b1, 1'b1);
      begin
        k = 0;
        while (!dr && k < 2000) begin @(negedge clk); k++; end
        push_cyc = cyc;
      end
    join
    offset = push_cyc - start_cyc;
    for (int i = 1; i < 16; i++) send_frame(8'(i * 13), 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_full_trig", rx_trig, 1);
    check("t4_full_no_oe", oe, 0);
    started = 1'b0;
    fork
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
      begin
        while (!started) @(negedge clk);
        while (cyc < start_cyc + offset - 1) @(negedge clk);
        e = exp_q.pop_front();
        check("t4_head_before_pop", {21'h0, bi_o, fe_o, pe_o, rbr}, {21'h0, e});
        man_rd = 1'b1;
        @(posedge clk);
        #1 man_rd = 1'b0;
      end
    join
    @(negedge clk);
    check("t4_pop_push_no_oe", oe, 0);
    auto_read = 1'b1;
    drain("t4b");

    // break: 30 bit times low, then a normal character
    rxfiftl = 2'd0;
    exp_q.push_back(model(8'h00, 1'b0, 1'b0, wls, pen, eps, sp));
    align_tick();
    rxd = 1'b0;
    repeat (30 * 64) @(posedge clk);
    #2 rxd = 1'b1;
    repeat (2 * 64) @(posedge clk);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    drain("t5");
    check("t5_dr_after", dr, 0);

    // trigger level 4 and character timeout
    auto_read = 1'b0; rxfiftl = 2'd1;
    for (int i = 0; i < 3; i++) send_frame(8'(8'h30 + i), 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("t6_trig_3", rx_trig, 0);
    lim = 4 * 16 * (2 + 5 + 3 + 0);
    fork
      send_frame(8'h33, 1'b0, 1'b1, 1'b1);
      begin
        k = 0;
        while (!rx_trig && k < 2000) begin @(negedge clk); k++; end
        check("t6_trig_4", rx_trig, 1);
        n = 0;
        while (n < lim - 1) begin @(posedge clk); if (bclk_en === 1'b1) n++; end
        @(negedge clk);
        check("t6_timeout_before", rx_timeout, 0);
        while (n < lim) begin @(posedge clk); if (bclk_en === 1'b1) n++; end
        @(negedge clk);
        check("t6_timeout_at_limit", rx_timeout, 1);
      end
    join
    auto_read = 1'b1;
    drain("t6");
    check("t6_timeout_cleared", rx_timeout, 0);

    // randomized characters and line settings
    for (int i = 0; i < 20; i++) begin
      wls    = 2'($urandom_range(0, 3));
      pen    = 1'($urandom_range(0, 1));
      eps    = 1'($urandom_range(0, 1));
      sp     = 1'($urandom_range(0, 1));
      fifoen = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 1'b1);
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
